// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control path.
// Used by multicycle_controller and alu_decoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      logic [1:0] imm;
      imm = IMM_I;
      case (op)
         OP_STORE:  imm = IMM_S;
         OP_BRANCH: imm = IMM_B;
         OP_JAL:    imm = IMM_J;
         default:   imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields onto the ALU operation code.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only register-register ops honour funct7b5; addi must stay an add.
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default:   alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Fetch/decode/execute/memory/writeback control FSM for the multicycle RISC-V core.
// Define CTRL_BNE_EN to also accept bne (funct3=001) as a branch.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = StFetch
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic       IllegalOp
);

   state_t     state_q, state_d;
   state_t     cur_state;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;
   logic       taken;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef CTRL_BNE_EN
   assign taken = funct3[0] ? ~Zero : Zero;
`else
   assign taken = Zero;
`endif

   always_comb begin
      state_d   = StFetch;
      pc_update = 1'b0;
      branch    = 1'b0;
      alu_op    = ALUOP_ADD;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
      // During reset the outputs follow FETCH regardless of the stale state.
      cur_state = reset_n ? state_q : StFetch;

      case (cur_state)
         StFetch: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = MemReady;
            pc_update = MemReady;
            state_d   = MemReady ? StDecode : StFetch;
         end
         StDecode: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = StMemAdr;
               OP_RTYPE:          state_d = StExecR;
               OP_ITYPE:          state_d = StExecI;
               OP_JAL:            state_d = StJal;
               OP_BRANCH: begin
`ifdef CTRL_BNE_EN
                  if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
`else
                  if (funct3 == F3_BEQ) begin
`endif
                     state_d = StBranch;
                  end else begin
                     state_d   = StFetch;
                     IllegalOp = 1'b1;
                  end
               end
               default: begin
                  state_d   = StFetch;
                  IllegalOp = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            state_d = op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            state_d = MemReady ? StMemWb : StMemRead;
         end
         StMemWb: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            state_d  = MemReady ? StFetch : StMemWrite;
         end
         StExecR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_FUNCT;
            state_d = StAluWb;
         end
         StExecI: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = StAluWb;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StBranch: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         default: state_d = StFetch;
      endcase

      PCWrite = pc_update | (branch & taken);

      if (!reset_n) begin
         PCWrite   = 1'b0;
         IRWrite   = 1'b0;
         MemWrite  = 1'b0;
         RegWrite  = 1'b0;
         IllegalOp = 1'b0;
      end
   end

   assign ImmSrc = imm_src_of(op);

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: an instruction-level model
// expands each instruction into its expected per-cycle control outputs.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   int checks = 0;
   int failures = 0;

   logic [16:0] exp_q[$];
   string       tag_q[$];

   typedef enum int {PhF, PhD, PhMA, PhMR, PhMWB, PhMW, PhER, PhEI, PhAW, PhBR, PhJ, PhRst}
      phase_e;
   typedef enum int {KLw, KSw, KR, KI, KBr, KJal, KIll} kind_e;

   multicycle_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegWrite   (RegWrite),
      .ALUControl (ALUControl),
      .IllegalOp  (IllegalOp)
   );

   always #5 clk = ~clk;

   // Expected control word for one cycle of an instruction in a given phase.
   function automatic logic [16:0] expect_out(input phase_e ph, input logic mr, input logic z,
                                               input logic [6:0] o, input logic [2:0] f3,
                                               input logic f7, input logic ill);
      logic       pcw, adr, mw, irw, rw, il;
      logic [1:0] res, sa, sb, imm;
      logic [2:0] alu;
      {pcw, adr, mw, irw, rw, il} = 6'b0;
      res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
      if (o == 7'b0100011)      imm = 2'b01;
      else if (o == 7'b1100011) imm = 2'b10;
      else if (o == 7'b1101111) imm = 2'b11;
      else                      imm = 2'b00;
      case (ph)
         PhF:   begin pcw = mr; irw = mr; sb = 2'b10; res = 2'b10; end
         PhRst: begin sb = 2'b10; res = 2'b10; end
         PhD:   begin sa = 2'b01; sb = 2'b01; il = ill; end
         PhMA:  begin sa = 2'b10; sb = 2'b01; end
         PhMR:  adr = 1'b1;
         PhMWB: begin res = 2'b01; rw = 1'b1; end
         PhMW:  begin adr = 1'b1; mw = 1'b1; end
         PhER, PhEI: begin
            sa = 2'b10;
            sb = (ph == PhEI) ? 2'b01 : 2'b00;
            case (f3)
               3'b000:  alu = (ph == PhER && f7) ? 3'b001 : 3'b000;
               3'b010:  alu = 3'b101;
               3'b110:  alu = 3'b011;
               3'b111:  alu = 3'b010;
               default: alu = 3'b000;
            endcase
         end
         PhAW:  rw = 1'b1;
         PhBR: begin
            sa = 2'b10; alu = 3'b001;
`ifdef CTRL_BNE_EN
            pcw = (f3 == 3'b001) ? !z : z;
`else
            pcw = z;
`endif
         end
         PhJ:   begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         default: ;
      endcase
      return {pcw, adr, mw, irw, res, sa, sb, imm, rw, alu, il};
   endfunction

   task automatic drive(input phase_e ph, input logic mr, input logic z, input logic rst,
                        input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic ill);
      @(posedge clk);
      #1;
      reset_n  = !rst;
      MemReady = mr;
      Zero     = z;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      exp_q.push_back(expect_out(rst ? PhRst : ph, mr, z, o, f3, f7, ill));
      tag_q.push_back($sformatf("%s%s op=%b f3=%b f7=%b mr=%b z=%b", rst ? "reset-in-" : "",
                                ph.name(), o, f3, f7, mr, z));
   endtask

   // none_ph (PhRst) disables stall/abort injection.
   task automatic run_instr(input kind_e k, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input int zero_mode, input phase_e stall_ph,
                            input int stalls, input phase_e abort_ph, input bit rnd);
      phase_e ph[$];
      int     n;
      logic   mr, z, rst;
      bit     wait_ph;
      case (k)
         KLw:  ph = '{PhF, PhD, PhMA, PhMR, PhMWB};
         KSw:  ph = '{PhF, PhD, PhMA, PhMW};
         KR:   ph = '{PhF, PhD, PhER, PhAW};
         KI:   ph = '{PhF, PhD, PhEI, PhAW};
         KBr:  ph = '{PhF, PhD, PhBR};
         KJal: ph = '{PhF, PhD, PhJ, PhAW};
         default: ph = '{PhF, PhD};
      endcase
      for (int i = 0; i < ph.size(); i++) begin
         n = 0;
         forever begin
            wait_ph = (ph[i] == PhF) || (ph[i] == PhMR) || (ph[i] == PhMW);
            if (ph[i] == stall_ph)  mr = (n >= stalls);
            else if (!wait_ph)      mr = 1'($urandom);
            else if (rnd)           mr = ($urandom_range(0, 2) != 0);
            else                    mr = 1'b1;
            z   = (zero_mode < 0) ? 1'($urandom) : zero_mode[0];
            rst = (ph[i] == abort_ph) || (rnd && $urandom_range(0, 59) == 0);
            drive(ph[i], mr, z, rst, o, f3, f7, k == KIll);
            if (rst) return;
            n++;
            if (!wait_ph || mr) break;
         end
      end
   endtask

   function automatic bit legal_op(input logic [6:0] o);
      return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
   endfunction

   // Monitor: one control word presented per cycle, compared mid-cycle.
   always @(negedge clk) begin
      logic [16:0] got, e;
      string       t;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                RegWrite, ALUControl, IllegalOp};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL %s got=%b required=%b (PCW,Adr,MW,IRW,Res,A,B,Imm,RW,ALU,Ill)",
                     t, got, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      kind_e      k;
      logic [6:0] o;
      logic [2:0] f3;
      // Two reset cycles with memory ready: FETCH values, all enables low.
      drive(PhF, 1'b1, 1'b0, 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
      drive(PhF, 1'b1, 1'b0, 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0);
      run_instr(KLw,  7'b0000011, 3'b010, 1'b0, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KSw,  7'b0100011, 3'b010, 1'b0, 0,  PhMW,  3, PhRst, 1'b0);
      run_instr(KR,   7'b0110011, 3'b000, 1'b1, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KI,   7'b0010011, 3'b000, 1'b1, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KR,   7'b0110011, 3'b010, 1'b0, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KBr,  7'b1100011, 3'b000, 1'b0, 1,  PhRst, 0, PhRst, 1'b0);
      run_instr(KBr,  7'b1100011, 3'b000, 1'b0, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KJal, 7'b1101111, 3'b000, 1'b0, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KIll, 7'b1111111, 3'b000, 1'b0, 0,  PhRst, 0, PhRst, 1'b0);
      run_instr(KR,   7'b0110011, 3'b111, 1'b0, 0,  PhRst, 0, PhER,  1'b0);
      run_instr(KLw,  7'b0000011, 3'b010, 1'b0, 0,  PhMR,  2, PhRst, 1'b0);

      for (int i = 0; i < 300; i++) begin
         k  = kind_e'($urandom_range(0, 6));
         f3 = 3'($urandom);
         case (k)
            KLw:  o = 7'b0000011;
            KSw:  o = 7'b0100011;
            KR:   o = 7'b0110011;
            KI:   o = 7'b0010011;
            KJal: o = 7'b1101111;
            KBr: begin
               o = 7'b1100011;
`ifdef CTRL_BNE_EN
               f3 = 3'($urandom_range(0, 1));
`else
               f3 = 3'b000;
`endif
            end
            default: begin
               if ($urandom_range(0, 1) == 0) begin
                  do o = 7'($urandom); while (legal_op(o));
               end else begin
                  o = 7'b1100011;
`ifdef CTRL_BNE_EN
                  do f3 = 3'($urandom); while (f3 == 3'b000 || f3 == 3'b001);
`else
                  do f3 = 3'($urandom); while (f3 == 3'b000);
`endif
               end
            end
         endcase
         run_instr(k, o, f3, 1'($urandom), -1, PhRst, 0, PhRst, 1'b1);
      end

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RISC-V core. It is the initiator side of the ALU interface: it issues ALUControl and consumes Zero.
- It decodes op/funct3/funct7b5 and sequences fetch/decode/execute/memory/writeback.
- It drives datapath mux selects and write enables, and handshakes with the unified instruction/data memory through MemReady.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- op  input  7  instruction opcode (Instr[6:0])
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory access complete this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  A mux: 00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  B mux: 00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file write enable
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalOp  output  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Clock and reset: one clock; synchronous active-low reset. reset_n=0 at a clock edge forces state := FETCH.
- While reset_n=0, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced 0. Other outputs take their FETCH values.
- Reset mid-instruction abandons it; no write enable asserts in the reset cycle.
- State register: 4 bits. Encodings are FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10. Encodings 11-15 go to FETCH.
- Moore outputs per state (unlisted outputs are 0 or 00):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=MemReady. PCUpdate=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held until MemReady).
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero).
- Transitions:
  - FETCH -> DECODE when MemReady=1, else stay.
  - DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 with funct3=000 -> BRANCH; 1101111 -> JAL.
  - DECODE, any other op/funct3: -> FETCH with IllegalOp=1 for that DECODE cycle only. That instruction makes no register or memory write; the PC was already advanced by 4.
  - MEMADR -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD -> MEMWB when MemReady=1, else stay.
  - MEMWRITE -> FETCH when MemReady=1, else stay (MemWrite held).
  - EXECR, EXECI, JAL -> ALUWB.
  - MEMWB, ALUWB, BRANCH -> FETCH.
- ImmSrc is combinational from op, independent of state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- ALU decode (combinational from the internal 2-bit ALUOp):
  - ALUOp 00 -> 000; ALUOp 01 -> 001; ALUOp 11 -> 000.
  - ALUOp 10, funct3 000: 001 if (op[5] & funct7b5) else 000.
  - ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Latency with MemReady tied 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4 cycles. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined: op 1100011 with funct3=001 also goes to BRANCH. In BRANCH, PCWrite = Branch & (funct3[0] ? ~Zero : Zero).
- Undefined: funct3=001 branches are illegal (IllegalOp pulse, return to FETCH). PCWrite = PCUpdate | (Branch & Zero).

Decomposition:
- Package ctrl_pkg holds:
  - state enum (4-bit) and opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - ALUOp and ImmSrc constants.
- One sub-module: alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl), combinational. The FSM and output decode stay in the top.

Test Plan:
- Reset: reset_n=0 for 2 cycles with MemReady=1 -> state FETCH; PCWrite, IRWrite, MemWrite, RegWrite all 0. After release, IRWrite=1 and PCWrite=1 on the first cycle.
- lw (op=0000011), MemReady=1 -> visits FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 only in cycle 5; AdrSrc=1 in MEMREAD.
- sw (op=0100011) with MemReady low 3 cycles in MEMWRITE -> MemWrite held high for 4 cycles, then FETCH. ImmSrc=01 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. Same encoding with op=0010011 -> ALUControl=000 (addi). funct3=010 -> ALUControl=101.
- beq: Zero=1 -> PCWrite=1 in BRANCH, ALUControl=001, 3-cycle instruction. Zero=0 -> PCWrite=0 in BRANCH.
- op=1111111 -> IllegalOp=1 for exactly one cycle in DECODE, then FETCH, no RegWrite/MemWrite. Reset asserted in EXECR -> next state FETCH and no ALUWB write.
